// File: rtl/switch_pkg.sv
// Shared definitions for the switch ingress path: header/descriptor field
// positions, frame limits, parser state encoding and a descriptor packer.
package switch_pkg;

    localparam int MAX_FRAME = 1600;
    localparam int MIN_LEN   = 16;

    localparam int HDR_LEN_HI_MSB  = 7;
    localparam int HDR_LEN_HI_LSB  = 4;
    localparam int HDR_PORTMAP_MSB = 3;
    localparam int HDR_PORTMAP_LSB = 0;

    localparam int DESC_ERR_BIT     = 15;
    localparam int DESC_PORTMAP_MSB = 14;
    localparam int DESC_PORTMAP_LSB = 11;
    localparam int DESC_LEN_MSB     = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR1 = 3'd1,
        BODY = 3'd2,
        PAD  = 3'd3,
        DROP = 3'd4
    } state_t;

    function automatic logic [15:0] make_desc(input logic err,
                                              input logic [3:0] portmap,
                                              input logic [10:0] len);
        logic [15:0] d;
        d = '0;
        d[DESC_ERR_BIT] = err;
        d[DESC_PORTMAP_MSB:DESC_PORTMAP_LSB] = portmap;
        d[DESC_LEN_MSB:0] = len;
        return d;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/switch_ingress_parser.sv
// Ingress frame parser: decodes the 2-byte switch header, forwards body bytes
// to the data FIFO, emits one descriptor per frame and drives back-pressure.
module switch_ingress_parser
    import switch_pkg::*;
#(
    parameter int MAX_FRAME = switch_pkg::MAX_FRAME,
    parameter int MIN_LEN   = switch_pkg::MIN_LEN,
    parameter int DFREE_W   = 12
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sof,
    input  logic               dv,
    input  logic [7:0]         data,
    output logic               bp,
    output logic               dfifo_wr,
    output logic [7:0]         dfifo_din,
    input  logic [DFREE_W-1:0] dfifo_free,
    output logic               ptr_fifo_wr,
    output logic [15:0]        ptr_fifo_din,
    input  logic               ptr_fifo_full,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        frame_cnt
);

    localparam logic [DFREE_W-1:0] BP_LEVEL  = DFREE_W'(MAX_FRAME);
    localparam logic [11:0]        MIN_LEN_V = 12'(MIN_LEN);

    state_t      state, state_next;
    logic [3:0]  portmap, len_hi;
    logic [10:0] body_len, wcnt, wcnt_inc, body_len_c;
    logic [11:0] len_c;
    logic        desc_pend;
    logic [15:0] desc_hold;
    logic        start, hdr_bad, take_byte, last_byte, trunc, drop_en;
    logic        dfifo_wr_n, ptr_wr_n;
    logic [15:0] ptr_din_n;

    // A sof with dv opens a new frame from any state except the second header byte.
    assign start      = dv & sof & (state != HDR1);
    assign len_c      = {len_hi, data};
    assign body_len_c = len_c[10:0] - 11'd2;
    assign hdr_bad    = (len_c < MIN_LEN_V) | (dfifo_free < DFREE_W'(body_len_c)) | ptr_fifo_full;
    assign take_byte  = (state == BODY) & dv & ~sof;
    assign wcnt_inc   = wcnt + 11'd1;
    assign last_byte  = take_byte & (wcnt_inc == body_len);
    assign trunc      = (state == BODY) & (~dv | sof);
    assign drop_en    = (state == HDR1) & dv & hdr_bad;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = HDR1;
            HDR1: begin
                if (!dv)          state_next = IDLE;
                else if (hdr_bad) state_next = DROP;
                else              state_next = BODY;
            end
            BODY: begin
                if (!dv)            state_next = IDLE;
                else if (sof)       state_next = HDR1;
                else if (last_byte) state_next = PAD;
            end
            PAD, DROP: begin
                if (start)    state_next = HDR1;
                else if (!dv) state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    // A normally completed frame posts its descriptor one cycle late (via
    // desc_pend); a truncated one is detected a cycle after its last byte.
    always_comb begin
        dfifo_wr_n = take_byte;
        ptr_wr_n   = desc_pend | trunc;
        ptr_din_n  = desc_pend ? desc_hold : make_desc(1'b1, portmap, wcnt);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bp           <= 1'b0;
            dfifo_wr     <= 1'b0;
            dfifo_din    <= '0;
            ptr_fifo_wr  <= 1'b0;
            ptr_fifo_din <= '0;
            desc_pend    <= 1'b0;
            desc_hold    <= '0;
            portmap      <= '0;
            len_hi       <= '0;
            body_len     <= '0;
            wcnt         <= '0;
        end else begin
            bp          <= (dfifo_free < BP_LEVEL) | ptr_fifo_full;
            dfifo_wr    <= dfifo_wr_n;
            ptr_fifo_wr <= ptr_wr_n;
            desc_pend   <= last_byte;
            if (take_byte) dfifo_din <= data;
            if (ptr_wr_n)  ptr_fifo_din <= ptr_din_n;
            if (last_byte) desc_hold <= make_desc(1'b0, portmap, body_len);
            if (start) begin
                portmap <= data[HDR_PORTMAP_MSB:HDR_PORTMAP_LSB];
                len_hi  <= data[HDR_LEN_HI_MSB:HDR_LEN_HI_LSB];
            end
            if (state == HDR1) begin
                body_len <= body_len_c;
                wcnt     <= '0;
            end else if (take_byte) begin
                wcnt <= wcnt_inc;
            end
        end
    end

    sat_counter16 u_drop_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .en    (drop_en),
        .count (drop_cnt)
    );

    sat_counter16 u_frame_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .en    (ptr_fifo_wr),
        .count (frame_cnt)
    );

endmodule
